musb_ifetch_unit: RTL and testbench
===================================

Name: musb_ifetch_unit

Overview:
Instruction-fetch responder on the far side of the PC register. It takes the registered PC, drives the instruction-memory/ICache request port and returns the fetched word to IF/ID. It raises if_mem_stall to freeze the PC while a fetch is pending. It also discards in-flight fetches on pipeline flush and reports misaligned-PC and bus-timeout exceptions.

Parameters:
BUS_TIMEOUT, 255, number of cycles a request may stay unanswered before an instruction-bus error is raised (1..65535).
NOP_INSTR, 32'h0000_0000, value loaded into if_instruction on reset and on flush.

Ports:
clk  input  1  main clock
rst  input  1  main reset; synchronous, active-high
if_pc  input  32  current PC from PC register
if_flush  input  1  branch, jump or exception redirect; abandons the current fetch
id_stall  input  1  ID stage cannot accept an instruction
if_mem_stall  output  1  freeze PC register (feeds the PC register's if_stall)
if_instruction  output  32  fetched instruction, registered
if_valid  output  1  if_instruction holds a valid word
if_exc_misaligned  output  1  if_pc[1:0] != 0, registered, sticky
if_exc_bus_error  output  1  fetch timed out, registered, sticky
imem_address  output  30  word address
imem_request  output  1  fetch request
imem_data  input  32  returned word
imem_ready  input  1  one-cycle acknowledge; imem_data is valid in the same cycle

Behaviour:
- States: REQ, DISCARD, ERROR. Reset state: REQ.
- Reset values: if_instruction=NOP_INSTR, if_valid=0, both exceptions 0, timeout counter 0, addr_q 0.
- While rst=1, imem_request is forced to 0, including mid-transaction.
- Request protocol:
  - Once imem_request is asserted, it stays high with a stable address until imem_ready.
  - addr_q <= if_pc[31:2] every cycle the block is in REQ.
- REQ state:
  - imem_request = !id_stall & (if_pc[1:0]==0).
  - imem_address = if_pc[31:2]. The PC is stable because if_mem_stall is high.
  - When imem_request & imem_ready & !if_flush:
    - capture: if_instruction<=imem_data, if_valid<=1;
    - stay in REQ;
    - if_mem_stall is low that cycle, so the PC advances.
  - Zero-wait memory therefore gives 1 fetch per cycle, with data visible at IF/ID one cycle after the request.
- Misaligned PC:
  - if_pc[1:0]!=0 in REQ with !if_flush: no request issued; if_exc_misaligned<=1; if_valid<=0; go to ERROR.
- if_flush while in REQ:
  - if_valid<=0, if_instruction<=NOP_INSTR.
  - If a request is outstanding without imem_ready, go to DISCARD.
  - If imem_ready arrives in the same cycle, drop the data and stay in REQ.
  - If no request is outstanding, stay in REQ.
- DISCARD state:
  - imem_request=1, imem_address=addr_q.
  - On imem_ready: drop imem_data and go to REQ.
  - if_flush in DISCARD: remain in DISCARD.
- ERROR state:
  - imem_request=0.
  - Exception outputs hold until if_flush, which clears both exceptions and returns to REQ.
- Timeout counter:
  - Clears on imem_ready, on a state change, and whenever imem_request=0.
  - Otherwise it increments each cycle imem_request=1.
  - When it reaches BUS_TIMEOUT in REQ: if_exc_bus_error<=1, if_valid<=0, go to ERROR.
  - When it reaches BUS_TIMEOUT in DISCARD: go to REQ silently, with no exception.
- if_mem_stall is combinational:
  - 1 when id_stall;
  - or in REQ when !(imem_request & imem_ready);
  - or in DISCARD;
  - or in ERROR.
  - 0 otherwise.
- if_valid and if_instruction update when no capture or flush occurs:
  - If id_stall=1: hold if_valid and if_instruction.
  - Else: if_valid<=0 (consumed).
- Priority: rst > if_flush > timeout > capture > hold.

Test Plan:
1. Reset, then if_pc=32'h0000_0100 with imem_ready tied 1 and imem_data=32'h2008_0005 -> one cycle later imem_address=30'h40, if_instruction=32'h2008_0005, if_valid=1; if_mem_stall=0 every cycle.
2. imem_ready delayed 3 cycles -> imem_request and imem_address held constant, if_mem_stall=1 for 3 cycles and 0 on the ready cycle; the word is captured exactly once.
3. if_flush one cycle after the request, with PC changing to 32'h0000_0200 and ready arriving 2 cycles later -> imem_address stays at 30'h40 until ready, the data is dropped (if_valid stays 0), and the next request has address 30'h80.
4. if_pc=32'h0000_0102 -> no request, if_exc_misaligned=1 next cycle and held, if_mem_stall=1; if_flush clears it and fetching resumes.
5. BUS_TIMEOUT=4 with imem_ready held 0 -> if_exc_bus_error=1 after 4 request cycles, imem_request drops, and the state holds until if_flush.
6. id_stall=1 during a captured valid word -> if_instruction and if_valid hold and imem_request=0; on release, the next fetch issues in the same cycle.

Source files
------------

// File: rtl/musb_ifetch_unit.sv
// Instruction-fetch responder: turns the registered PC into an imem request and registers the returned word for IF/ID.
// Latency: with a zero-wait memory, the word appears on if_instruction one cycle after the request.
// Backpressure: id_stall holds the IF/ID word and suppresses new requests. if_mem_stall freezes the PC while a fetch is pending.
module musb_ifetch_unit #(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic        if_flush,
  input  logic        id_stall,
  output logic        if_mem_stall,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        if_exc_misaligned,
  output logic        if_exc_bus_error,
  output logic [29:0] imem_address,
  output logic        imem_request,
  input  logic [31:0] imem_data,
  input  logic        imem_ready
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_DISCARD = 2'd1;
  localparam logic [1:0] S_ERROR   = 2'd2;

  // The timeout fires on the BUS_TIMEOUT-th consecutive unanswered request cycle.
  localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [29:0] addr_q;
  logic [15:0] tmo_cnt;
  logic        pc_aligned;
  logic        fetch_done;
  logic        timeout;

  assign pc_aligned = (if_pc[1:0] == 2'b00);
  assign fetch_done = imem_request && imem_ready;
  assign timeout    = imem_request && !imem_ready && (tmo_cnt == TIMEOUT_LAST);

  // Request port. In DISCARD, the abandoned address is replayed until memory acknowledges it.
  always_comb begin
    imem_request = 1'b0;
    imem_address = addr_q;
    case (state)
      S_REQ: begin
        imem_request = !id_stall && pc_aligned;
        imem_address = if_pc[31:2];
      end
      S_DISCARD: imem_request = 1'b1;
      default: imem_request = 1'b0;
    endcase
    if (rst) imem_request = 1'b0;
  end

  // The PC may only advance on the cycle a word is actually accepted from memory.
  always_comb begin
    if_mem_stall = id_stall || (state != S_REQ) || !fetch_done;
  end

  // Next-state selection. Flush has priority over misalignment and timeout in REQ.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (if_flush)
          state_nxt = (imem_request && !imem_ready) ? S_DISCARD : S_REQ;
        else if (!pc_aligned || timeout)
          state_nxt = S_ERROR;
      end
      S_DISCARD: if (imem_ready || timeout) state_nxt = S_REQ;
      S_ERROR:   if (if_flush) state_nxt = S_REQ;
      default:   state_nxt = S_REQ;
    endcase
  end

  // State register, plus the address latch that lets DISCARD replay the abandoned request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_REQ) addr_q <= if_pc[31:2];
    end
  end

  // Timeout counter. It counts consecutive unanswered request cycles within one state.
  always_ff @(posedge clk) begin
    if (rst || !imem_request || imem_ready || (state_nxt != state))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end

  // IF/ID word. Priority is flush, then error entry, then capture, then hold or consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_instruction <= NOP_INSTR;
      if_valid       <= 1'b0;
    end else if (if_flush) begin
      if_instruction <= NOP_INSTR;
      if_valid       <= 1'b0;
    end else if ((state == S_REQ) && (!pc_aligned || timeout)) begin
      if_valid       <= 1'b0;
    end else if ((state == S_REQ) && fetch_done) begin
      if_instruction <= imem_data;
      if_valid       <= 1'b1;
    end else if (!id_stall) begin
      if_valid       <= 1'b0;
    end
  end

  // Sticky exception flags. They are raised on entry to ERROR and cleared only by a flush out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_exc_misaligned <= 1'b0;
      if_exc_bus_error  <= 1'b0;
    end else if ((state == S_ERROR) && if_flush) begin
      if_exc_misaligned <= 1'b0;
      if_exc_bus_error  <= 1'b0;
    end else if ((state == S_REQ) && !if_flush) begin
      if (!pc_aligned)  if_exc_misaligned <= 1'b1;
      else if (timeout) if_exc_bus_error  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_musb_ifetch_unit.sv
// Bench for musb_ifetch_unit: directed walk-through of the fetch scenarios, then a randomized closed-loop run.
// In the random run, the bench acts as PC register and memory, and a scoreboard checks each word delivered to ID.
// A word is expected for every cycle in which the PC advances without a flush.
module tb_musb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_flush;
  logic        id_stall;
  logic        if_mem_stall;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        if_exc_misaligned;
  logic        if_exc_bus_error;
  logic [29:0] imem_address;
  logic        imem_request;
  logic [31:0] imem_data;
  logic        imem_ready;

  int vectors     = 0;
  int miscompares = 0;
  bit sb_en       = 1'b0;
  logic [31:0] exp_q[$];

  musb_ifetch_unit #(.BUS_TIMEOUT(4), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_flush(if_flush), .id_stall(id_stall),
    .if_mem_stall(if_mem_stall), .if_instruction(if_instruction), .if_valid(if_valid),
    .if_exc_misaligned(if_exc_misaligned), .if_exc_bus_error(if_exc_bus_error),
    .imem_address(imem_address), .imem_request(imem_request),
    .imem_data(imem_data), .imem_ready(imem_ready)
  );

  always #5 clk = ~clk;

  // The memory image is a fixed function of the word address.
  function automatic logic [31:0] word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // This task applies one cycle of inputs just after the clock edge, then waits for the next negedge for sampling.
  task automatic drive(input logic [31:0] pc, input logic fl, input logic st,
                       input logic rdy, input logic [31:0] dat);
    @(posedge clk); #1;
    if_pc = pc; if_flush = fl; id_stall = st; imem_ready = rdy; imem_data = dat;
    @(negedge clk);
  endtask

  // Scoreboard monitor. Every word consumed by ID must match the oldest expected word. A flush kills pending words.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (if_flush) begin
        exp_q.delete();
      end else if (if_valid && !id_stall) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_word: got unexpected word %h, expected none", if_instruction);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (if_instruction !== e) begin
            miscompares++;
            $display("FAIL sb_word: got %h, expected %h", if_instruction, e);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] pc_nxt;
    logic [31:0] flush_tgt;
    logic [29:0] pend_addr;
    logic        pend;
    int          mem_wait;

    rst = 1'b1; if_pc = 32'h100; if_flush = 1'b0; id_stall = 1'b0;
    imem_ready = 1'b0; imem_data = '0;
    @(negedge clk);
    chk("rst_req",   32'(imem_request), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instruction, NOP);
    chk("rst_exc",   32'({if_exc_misaligned, if_exc_bus_error}), 32'd0);

    // zero-wait fetch
    @(posedge clk); #1;
    rst = 1'b0; imem_ready = 1'b1; imem_data = 32'h2008_0005;
    @(negedge clk);
    chk("t1_req",   32'(imem_request), 32'd1);
    chk("t1_addr",  32'(imem_address), 32'h40);
    chk("t1_stall", 32'(if_mem_stall), 32'd0);
    drive(32'h100, 0, 0, 1, 32'h2008_0005);
    chk("t1_instr", if_instruction, 32'h2008_0005);
    chk("t1_valid", 32'(if_valid), 32'd1);
    chk("t1_stall2", 32'(if_mem_stall), 32'd0);

    // three wait cycles, then ready
    for (int i = 0; i < 3; i++) begin
      drive(32'h104, 0, 0, 0, 32'h1111_1111);
      chk("t2_req",   32'(imem_request), 32'd1);
      chk("t2_addr",  32'(imem_address), 32'h41);
      chk("t2_stall", 32'(if_mem_stall), 32'd1);
    end
    chk("t2_valid_wait", 32'(if_valid), 32'd0);
    drive(32'h104, 0, 0, 1, 32'hCAFE_F00D);
    chk("t2_stall_rdy", 32'(if_mem_stall), 32'd0);
    chk("t2_addr_rdy",  32'(imem_address), 32'h41);

    // id_stall holds the word and suppresses requests
    for (int i = 0; i < 2; i++) begin
      drive(32'h108, 0, 1, 0, 32'h0);
      chk("t6_valid", 32'(if_valid), 32'd1);
      chk("t6_instr", if_instruction, 32'hCAFE_F00D);
      chk("t6_req",   32'(imem_request), 32'd0);
    end
    drive(32'h108, 0, 0, 1, 32'h3333_3333);
    chk("t6_req_rel",  32'(imem_request), 32'd1);
    chk("t6_addr_rel", 32'(imem_address), 32'h42);
    chk("t6_stall_rel", 32'(if_mem_stall), 32'd0);
    drive(32'h10C, 0, 1, 0, 32'h0);
    chk("t6_instr2", if_instruction, 32'h3333_3333);

    // flush with a request outstanding
    drive(32'h100, 0, 0, 0, 32'h0);
    chk("t3_addr_a", 32'(imem_address), 32'h40);
    drive(32'h100, 1, 0, 0, 32'h0);
    chk("t3_req_b", 32'(imem_request), 32'd1);
    drive(32'h200, 0, 0, 0, 32'h0);
    chk("t3_addr_c",  32'(imem_address), 32'h40);
    chk("t3_req_c",   32'(imem_request), 32'd1);
    chk("t3_valid_c", 32'(if_valid), 32'd0);
    chk("t3_instr_c", if_instruction, NOP);
    drive(32'h200, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t3_addr_d",  32'(imem_address), 32'h40);
    chk("t3_stall_d", 32'(if_mem_stall), 32'd1);
    drive(32'h200, 0, 0, 1, 32'h4444_4444);
    chk("t3_valid_e", 32'(if_valid), 32'd0);
    chk("t3_addr_e",  32'(imem_address), 32'h80);
    chk("t3_stall_e", 32'(if_mem_stall), 32'd0);
    drive(32'h204, 0, 1, 0, 32'h0);
    chk("t3_instr_f", if_instruction, 32'h4444_4444);

    // misaligned PC
    drive(32'h102, 0, 0, 0, 32'h0);
    chk("t4_req",   32'(imem_request), 32'd0);
    chk("t4_stall", 32'(if_mem_stall), 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(32'h102, 0, 0, 0, 32'h0);
      chk("t4_exc",   32'(if_exc_misaligned), 32'd1);
      chk("t4_req_e", 32'(imem_request), 32'd0);
      chk("t4_valid", 32'(if_valid), 32'd0);
    end
    drive(32'h102, 1, 0, 0, 32'h0);
    drive(32'h104, 0, 0, 1, 32'h5555_5555);
    chk("t4_exc_clr", 32'(if_exc_misaligned), 32'd0);
    chk("t4_resume",  32'(imem_address), 32'h41);
    drive(32'h108, 0, 1, 0, 32'h0);
    chk("t4_instr", if_instruction, 32'h5555_5555);

    // bus timeout
    for (int i = 0; i < 4; i++) begin
      drive(32'h108, 0, 0, 0, 32'h0);
      chk("t5_req", 32'(imem_request), 32'd1);
      chk("t5_err_early", 32'(if_exc_bus_error), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(32'h108, 0, 0, 0, 32'h0);
      chk("t5_err",   32'(if_exc_bus_error), 32'd1);
      chk("t5_req_e", 32'(imem_request), 32'd0);
      chk("t5_stall", 32'(if_mem_stall), 32'd1);
    end
    drive(32'h108, 1, 0, 0, 32'h0);
    drive(32'h10C, 0, 0, 1, 32'h6666_6666);
    chk("t5_err_clr", 32'(if_exc_bus_error), 32'd0);
    chk("t5_resume",  32'(imem_address), 32'h43);

    // reset mid-transaction
    drive(32'h110, 0, 0, 0, 32'h0);
    chk("rst_mid_pre", 32'(imem_request), 32'd1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", 32'(imem_request), 32'd0);
    @(negedge clk);
    chk("rst_mid_valid", 32'(if_valid), 32'd0);
    chk("rst_mid_instr", if_instruction, NOP);

    // randomized closed-loop run
    @(posedge clk); #1;
    rst = 1'b0; if_flush = 1'b0; id_stall = 1'b0; imem_ready = 1'b0;
    pc_nxt = 32'h1000; flush_tgt = '0; mem_wait = 0; pend = 1'b0; pend_addr = '0;
    sb_en = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      if_pc    = pc_nxt;
      if_flush = ($urandom_range(0, 15) == 0);
      if (if_flush) flush_tgt = 32'($urandom_range(0, 1023)) << 2;
      id_stall = ($urandom_range(0, 3) == 0);
      #1;
      imem_ready = 1'b0;
      imem_data  = $urandom;
      if (imem_request) begin
        if (mem_wait == 0) begin
          imem_ready = 1'b1;
          imem_data  = word(imem_address);
        end else begin
          mem_wait--;
        end
      end
      @(negedge clk); #1;
      if (pend && imem_request) chk("addr_stable", 32'(imem_address), 32'(pend_addr));
      pend      = imem_request && !imem_ready;
      pend_addr = imem_address;
      if (imem_request && imem_ready) mem_wait = $urandom_range(0, 2);
      if (!if_mem_stall && !if_flush) exp_q.push_back(word(if_pc[31:2]));
      pc_nxt = if_flush ? flush_tgt : (!if_mem_stall ? if_pc + 32'd4 : if_pc);
    end
    sb_en = 1'b0;
    chk("sb_backlog", 32'(exp_q.size() <= 1), 32'd1);
    chk("rand_exc", 32'({if_exc_misaligned, if_exc_bus_error}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
